eth_tx_arb: RTL

Frame-atomic round-robin arbiter that shares one 64-bit AXI-Stream MAC TX port among `NUM_SRC` frame generators (DNS-response, UDP flood and similar `eth_send`-style sources). It grants one source per frame and holds the grant until that source's `tlast` beat. It then inserts a programmable idle gap before re-arbitrating. It sits between the generator bank and the 10G MAC TX interface in the 156.25 MHz domain.

---
 rtl/eth_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 18 +
 rtl/eth_tx_arb.sv | 98 +++++++++
 3 files changed

// File: rtl/eth_arb_pkg.sv
// eth_arb_pkg: shared state type, source limit and round-robin helper for the MAC TX arbiter.
package eth_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_XFER,
        ARB_GAP
    } arb_state_t;

    localparam int ARB_MAX_SRC = 8;

    // Returns {found, index}: first set request scanning upward from last+1, wrapping at n.
    function automatic logic [3:0] rr_next(input logic [ARB_MAX_SRC-1:0] req, input logic [2:0] last,
                                           input int n);
        logic [3:0] r;
        int idx;
        r = '0;
        for (int k = ARB_MAX_SRC; k >= 1; k--) begin
            idx = (int'(last) + k) % n;
            if (k <= n && req[3'(idx)]) r = {1'b1, 3'(idx)};
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector over NUM_SRC requests.
module rr_pick
    import eth_arb_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [2:0]         i_last,
    output logic               o_found,
    output logic [2:0]         o_idx
);

    logic [ARB_MAX_SRC-1:0] w_req;

    assign w_req = ARB_MAX_SRC'(i_req);
    assign {o_found, o_idx} = rr_next(w_req, i_last, NUM_SRC);

endmodule

// File: rtl/eth_tx_arb.sv
// eth_tx_arb: frame-atomic round-robin arbiter sharing one 64-bit AXI-Stream MAC TX port.
// One source is granted per frame; an optional idle gap follows every tlast beat.
module eth_tx_arb
    import eth_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int IFG_CYCLES = 0
) (
    input  logic                   clk156,
    input  logic                   sys_rst_n,
    input  logic                   enable,
    input  logic [NUM_SRC-1:0]     s_axis_tvalid,
    input  logic [NUM_SRC*64-1:0]  s_axis_tdata,
    input  logic [NUM_SRC*8-1:0]   s_axis_tkeep,
    input  logic [NUM_SRC-1:0]     s_axis_tlast,
    input  logic [NUM_SRC-1:0]     s_axis_tuser,
    output logic [NUM_SRC-1:0]     s_axis_tready,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [63:0]            m_axis_tdata,
    output logic [7:0]             m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic [2:0]             grant_idx,
    output logic                   busy,
    output logic [31:0]            frame_cnt
);

    arb_state_t  r_state, w_next;
    logic [2:0]  r_grant;
    logic [15:0] r_gap;
    logic [31:0] r_frame;
    logic        r_busy;
    logic        w_found;
    logic [2:0]  w_pick;
    logic        w_last_beat;

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .i_req   (s_axis_tvalid),
        .i_last  (r_grant),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // Everything is forced to zero outside XFER, so the mux doubles as output gating.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_state == ARB_XFER && 3'(i) == r_grant) begin
                m_axis_tvalid    = s_axis_tvalid[i];
                m_axis_tdata     = s_axis_tdata[i*64 +: 64];
                m_axis_tkeep     = s_axis_tkeep[i*8 +: 8];
                m_axis_tlast     = s_axis_tlast[i];
                m_axis_tuser     = s_axis_tuser[i];
                s_axis_tready[i] = m_axis_tready;
            end
        end
    end

    assign w_last_beat = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE: if (enable && w_found) w_next = ARB_XFER;
            ARB_XFER: if (w_last_beat) w_next = (IFG_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
            ARB_GAP:  if (r_gap == '0) w_next = ARB_IDLE;
            default:  w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ARB_IDLE;
            r_grant <= 3'(NUM_SRC - 1);
            r_gap   <= '0;
            r_frame <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ARB_IDLE);
            if (r_state == ARB_IDLE && w_next == ARB_XFER) r_grant <= w_pick;
            if (w_last_beat) r_frame <= r_frame + 32'd1;
            if (w_last_beat && IFG_CYCLES != 0) r_gap <= 16'(IFG_CYCLES - 1);
            else if (r_state == ARB_GAP && r_gap != '0) r_gap <= r_gap - 16'd1;
        end
    end

    assign grant_idx = r_grant;
    assign busy      = r_busy;
    assign frame_cnt = r_frame;

endmodule
